mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares one memory port between two requesters: port 0 is fetch, port 1 is
//  the load/store unit. Requests are arbitrated round-robin, and each request
//  is tagged with its requester ID in an extra MSB of the opaque field.
//  Responses are routed back using that tag. Per-requester in-flight counters
//  cap how many requests each requester may have outstanding.
// PARAMETERS
//  p_opaq_bits      8   requester-side opaque width; memory side is p_opaq_bits+1
//  p_req_bits       67  request payload width excluding opaque (op,addr,len,data)
//  p_resp_bits      35  response payload width excluding opaque (op,len,data)
//  p_max_in_flight  8   maximum outstanding requests per requester, >=1
//  p_reset_prio     0   requester holding priority after reset (0 or 1)
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 synchronous, active-high reset
//  reqN_val       in   1                 N=0,1: request valid
//  reqN_rdy       out  1                 request ready
//  reqN_msg       in   p_req_bits        request payload
//  reqN_opaq      in   p_opaq_bits       request opaque
//  respN_val      out  1                 response valid
//  respN_rdy      in   1                 response ready
//  respN_msg      out  p_resp_bits       response payload
//  respN_opaq     out  p_opaq_bits       opaque with the tag bit stripped
//  mem_req_val    out  1                 memory request valid
//  mem_req_rdy    in   1                 memory request ready
//  mem_req_msg    out  p_req_bits        granted payload
//  mem_req_opaq   out  p_opaq_bits+1     {grant_id, reqN_opaq}
//  mem_resp_val   in   1                 memory response valid
//  mem_resp_rdy   out  1                 memory response ready
//  mem_resp_msg   in   p_resp_bits       memory response payload
//  mem_resp_opaq  in   p_opaq_bits+1     MSB is the destination ID
// BEHAVIOUR
//  - State: prio (1b), lock (1b), lock_id (1b),
//    cnt0/cnt1 ($clog2(p_max_in_flight+1) bits each).
//  - Reset: prio<=p_reset_prio, lock<=0, cnt0=cnt1=0.
//    While rst=1, force every val/rdy output to 0.
//  - Eligibility: eligN = reqN_val & (cntN < p_max_in_flight). cnt is the
//    registered value, so a response frees a slot from the next cycle.
//  - Grant (combinational, 0-cycle latency):
//    - lock=1: grant=lock_id.
//    - Otherwise, if both requesters are eligible, grant=prio; else grant the
//      single eligible requester.
//    - mem_req_val = lock | elig0 | elig1.
//    - reqN_rdy = mem_req_rdy & mem_req_val & (grant==N).
//  - Stability: if mem_req_val & !mem_req_rdy, then lock<=1 and lock_id<=grant.
//    The granted payload stays presented until it fires; requesters hold val
//    and msg stable per the val/rdy convention. A fire clears lock.
//  - Priority: on a request fire, prio<=~grant. With no fire, prio holds.
//  - Response routing (combinational):
//    - id = mem_resp_opaq[MSB].
//    - respN_val = mem_resp_val & id==N.
//    - mem_resp_rdy = resp[id]_rdy.
//    - respN_msg / respN_opaq are driven to both ports, tag stripped.
//  - Counters:
//    - cntN +1 on a request fire for N; -1 on a response fire for N.
//    - Both in the same cycle: unchanged.
//    - Response with cntN==0: simulation assertion fires; cnt stays 0.
//    - cntN never exceeds p_max_in_flight.
//  - No reordering: memory-side response order passes through unchanged.
//  - Reset mid-transaction: all state is cleared. In-flight responses arriving
//    after reset are a system error; the counter assertion flags them.
// CONFIGURATION
//  MEM_REQ_ARBITER_PERF_EN defined:
//    - Adds 32b outputs perf_grant0, perf_grant1: request fires per port.
//    - Adds 32b output perf_conflict: cycles with elig0 & elig1 and no lock.
//    - All wrap modulo 2^32 and reset to 0.
//  MEM_REQ_ARBITER_PERF_EN undefined:
//    - These ports and registers do not exist; arbitration is identical.
// TESTING
//  1. Only req0 valid, msg addr 0x200, opaq 0x05, mem_req_rdy=1
//     -> mem_req_opaq=0x005, req0_rdy=1.
//     Then mem_resp opaq 0x005
//     -> resp0_val=1, resp0_opaq=0x05, resp1_val=0.
//  2. Both requesters valid, mem_req_rdy=1 for 8 cycles, p_reset_prio=0
//     -> grant sequence 0,1,0,1,0,1,0,1.
//     perf_grant0=perf_grant1=4 when PERF_EN is defined.
//  3. Both valid, grant 0, mem_req_rdy=0 for 3 cycles
//     -> grant and payload stay on port 0 for 3 cycles; fire on cycle 4;
//     cycle 5 grants port 1.
//  4. p_max_in_flight=2, req0 fires twice with no responses
//     -> req0_rdy=0 and req1 is served.
//     After one resp to id 0, req0 is eligible the next cycle.
//  5. cnt0=1, req0 fire and resp0 fire in the same cycle
//     -> cnt0 stays 1.
//     resp with opaq MSB=1 while resp1_rdy=0
//     -> mem_resp_rdy=0 until resp1_rdy=1.
//  6. Assert rst while lock=1 and cnt1=3
//     -> all val/rdy outputs 0 during reset.
//     After reset, lock=0, cnt=0, prio=p_reset_prio, and the first grant
//     follows p_reset_prio.

Source files
------------

// File: rtl/mem_req_arbiter.sv
`timescale 1ns/1ps
// mem_req_arbiter
// Shares one memory port between fetch (port 0) and the load/store unit
// (port 1). Round-robin grant, requester ID carried in the memory-side opaque
// MSB, responses routed back by that bit, per-requester in-flight caps.
// Optional performance counters: define MEM_REQ_ARBITER_PERF_EN.
//
// state   | meaning
// st_open | no request stalled; grant chosen from eligible requesters
// st_held | granted request stalled by memory; grant held on lock_id_q
module mem_req_arbiter #(
   parameter int p_opaq_bits     = 8,
   parameter int p_req_bits      = 67,
   parameter int p_resp_bits     = 35,
   parameter int p_max_in_flight = 8,
   parameter bit p_reset_prio    = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_val,
   output logic                   req0_rdy,
   input  logic [p_req_bits-1:0]  req0_msg,
   input  logic [p_opaq_bits-1:0] req0_opaq,
   input  logic                   req1_val,
   output logic                   req1_rdy,
   input  logic [p_req_bits-1:0]  req1_msg,
   input  logic [p_opaq_bits-1:0] req1_opaq,
   output logic                   resp0_val,
   input  logic                   resp0_rdy,
   output logic [p_resp_bits-1:0] resp0_msg,
   output logic [p_opaq_bits-1:0] resp0_opaq,
   output logic                   resp1_val,
   input  logic                   resp1_rdy,
   output logic [p_resp_bits-1:0] resp1_msg,
   output logic [p_opaq_bits-1:0] resp1_opaq,
   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [p_req_bits-1:0]  mem_req_msg,
   output logic [p_opaq_bits:0]   mem_req_opaq,
   input  logic                   mem_resp_val,
   output logic                   mem_resp_rdy,
   input  logic [p_resp_bits-1:0] mem_resp_msg,
   input  logic [p_opaq_bits:0]   mem_resp_opaq
`ifdef MEM_REQ_ARBITER_PERF_EN
   ,
   output logic [31:0]            perf_grant0,
   output logic [31:0]            perf_grant1,
   output logic [31:0]            perf_conflict
`endif
);

   localparam int c_cnt_bits = $clog2(p_max_in_flight + 1);
   localparam logic [c_cnt_bits-1:0] c_max = c_cnt_bits'(p_max_in_flight);
   localparam logic [c_cnt_bits-1:0] c_one = c_cnt_bits'(1);

   typedef enum logic {st_open, st_held} arb_state_t;

   arb_state_t            state_q, state_d;
   logic                  lock_id_q, lock_id_d;
   logic                  prio_q, prio_d;
   logic [c_cnt_bits-1:0] cnt0_q, cnt1_q;
   logic                  elig0, elig1;
   logic                  grant, req_present, req_fire;
   logic                  req_fire0, req_fire1;
   logic                  resp_id, resp_fire0, resp_fire1;

   // Grant selection, request-side handshake and next arbitration state
   always_comb begin
      state_d     = state_q;
      lock_id_d   = lock_id_q;
      prio_d      = prio_q;
      elig0       = req0_val & (cnt0_q < c_max);
      elig1       = req1_val & (cnt1_q < c_max);
      grant       = prio_q;
      if (state_q == st_held) begin
         grant = lock_id_q;
      end else if (elig0 & elig1) begin
         grant = prio_q;
      end else if (elig1) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
      req_present  = (state_q == st_held) | elig0 | elig1;
      req_fire     = req_present & mem_req_rdy & ~rst;
      req_fire0    = req_fire & ~grant;
      req_fire1    = req_fire & grant;
      mem_req_val  = req_present & ~rst;
      req0_rdy     = mem_req_rdy & req_present & ~grant & ~rst;
      req1_rdy     = mem_req_rdy & req_present & grant & ~rst;
      mem_req_msg  = grant ? req1_msg : req0_msg;
      mem_req_opaq = {grant, (grant ? req1_opaq : req0_opaq)};
      if (req_fire) begin
         state_d = st_open;
         prio_d  = ~grant;
      end else if (req_present) begin
         state_d   = st_held;
         lock_id_d = grant;
      end
   end

   // Arbitration state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= st_open;
         lock_id_q <= 1'b0;
         prio_q    <= p_reset_prio;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         prio_q    <= prio_d;
      end
   end

   // Response routing by the tag bit; payload fans out to both ports
   always_comb begin
      resp_id      = mem_resp_opaq[p_opaq_bits];
      mem_resp_rdy = (resp_id ? resp1_rdy : resp0_rdy) & ~rst;
      resp0_val    = mem_resp_val & ~resp_id & ~rst;
      resp1_val    = mem_resp_val & resp_id & ~rst;
      resp0_msg    = mem_resp_msg;
      resp1_msg    = mem_resp_msg;
      resp0_opaq   = mem_resp_opaq[p_opaq_bits-1:0];
      resp1_opaq   = mem_resp_opaq[p_opaq_bits-1:0];
      resp_fire0   = mem_resp_val & mem_resp_rdy & ~resp_id;
      resp_fire1   = mem_resp_val & mem_resp_rdy & resp_id;
   end

   // In-flight counters; a request and response in the same cycle cancel
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (req_fire0 & ~resp_fire0) begin
            cnt0_q <= cnt0_q + c_one;
         end else if (resp_fire0 & ~req_fire0 & (cnt0_q != '0)) begin
            cnt0_q <= cnt0_q - c_one;
         end
         if (req_fire1 & ~resp_fire1) begin
            cnt1_q <= cnt1_q + c_one;
         end else if (resp_fire1 & ~req_fire1 & (cnt1_q != '0)) begin
            cnt1_q <= cnt1_q - c_one;
         end
      end
   end

   // A response with nothing outstanding means memory or reset sequencing is broken
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_resp0_underflow: assert (!(resp_fire0 && (cnt0_q == '0)));
         a_resp1_underflow: assert (!(resp_fire1 && (cnt1_q == '0)));
      end
   end

`ifdef MEM_REQ_ARBITER_PERF_EN
   // Grant and contention counters, free-running modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grant0   <= '0;
         perf_grant1   <= '0;
         perf_conflict <= '0;
      end else begin
         if (req_fire0) perf_grant0 <= perf_grant0 + 32'd1;
         if (req_fire1) perf_grant1 <= perf_grant1 + 32'd1;
         if (elig0 & elig1 & (state_q == st_open)) perf_conflict <= perf_conflict + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_req_arbiter: reset-state vector table, directed multi-cycle
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_req_arbiter;

   localparam int MAXF = 3;

   logic        clk, rst;
   logic        req0_val, req0_rdy, req1_val, req1_rdy;
   logic [66:0] req0_msg, req1_msg;
   logic [7:0]  req0_opaq, req1_opaq;
   logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic [34:0] resp0_msg, resp1_msg;
   logic [7:0]  resp0_opaq, resp1_opaq;
   logic        mem_req_val, mem_req_rdy;
   logic [66:0] mem_req_msg;
   logic [8:0]  mem_req_opaq;
   logic        mem_resp_val, mem_resp_rdy;
   logic [34:0] mem_resp_msg;
   logic [8:0]  mem_resp_opaq;
`ifdef MEM_REQ_ARBITER_PERF_EN
   logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

   int checks = 0;
   int errors = 0;

   mem_req_arbiter #(
      .p_opaq_bits(8), .p_req_bits(67), .p_resp_bits(35),
      .p_max_in_flight(MAXF), .p_reset_prio(1'b0)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg), .req0_opaq(req0_opaq),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg), .req1_opaq(req1_opaq),
      .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg), .resp0_opaq(resp0_opaq),
      .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg), .resp1_opaq(resp1_opaq),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
      .mem_req_opaq(mem_req_opaq),
      .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
      .mem_resp_opaq(mem_resp_opaq)
`ifdef MEM_REQ_ARBITER_PERF_EN
      , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
      req0_opaq = '0; req1_opaq = '0; resp0_rdy = 0; resp1_rdy = 0;
      mem_req_rdy = 0; mem_resp_val = 0; mem_resp_msg = '0; mem_resp_opaq = '0;
   endtask

   task automatic do_reset();
      rst = 1;
      clear_inputs();
      tick();
      tick();
      rst = 0;
   endtask

   typedef struct {
      logic       r0v, r1v, mrr, rv;
      logic [8:0] ro;
      logic       p0r, p1r;
      logic       e_mv, e_r0, e_r1;
      logic [8:0] e_mo;
      logic       e_s0v, e_s1v, e_mrr;
   } vec_t;

   localparam logic [66:0] MSG0 = 67'h200;
   localparam logic [66:0] MSG1 = 67'h4_0000_0000_0000_0BEE;

   vec_t vecs[10];

   // transaction-level reference state for the random phase
   int         m_cnt[2];
   int         m_last;
   int         m_stall;
   logic [8:0] memq[$];
   logic       rv[2];
   logic [7:0] ro[2];
   logic [66:0] rm[2];

   initial begin
      logic       e0, e1, ev, eg, rid, rrdy;
      logic [95:0] r96;
      logic [63:0] r64;

      rst = 1;
      clear_inputs();

      //             r0v   r1v   mrr   rv    ro        p0r   p1r   mv    r0    r1    mo        s0v   s1v   mrr
      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h005, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1A3, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h005, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h005, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'h005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'h1C7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'h1C7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h1C7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 9'h005, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h005, 1'b1, 1'b0, 1'b0};

      tick();
      tick();

      // each vector is evaluated from the post-reset state; reset is
      // re-asserted before the edge so no vector changes state
      for (int i = 0; i < 10; i++) begin
         rst = 0;
         req0_val = vecs[i].r0v; req1_val = vecs[i].r1v; mem_req_rdy = vecs[i].mrr;
         req0_opaq = 8'h05; req1_opaq = 8'hA3; req0_msg = MSG0; req1_msg = MSG1;
         mem_resp_val = vecs[i].rv; mem_resp_opaq = vecs[i].ro; mem_resp_msg = 35'h5_1234_5678;
         resp0_rdy = vecs[i].p0r; resp1_rdy = vecs[i].p1r;
         settle();
         chk($sformatf("vec%0d_mem_req_val", i), mem_req_val, vecs[i].e_mv);
         chk($sformatf("vec%0d_req0_rdy", i), req0_rdy, vecs[i].e_r0);
         chk($sformatf("vec%0d_req1_rdy", i), req1_rdy, vecs[i].e_r1);
         chk($sformatf("vec%0d_resp0_val", i), resp0_val, vecs[i].e_s0v);
         chk($sformatf("vec%0d_resp1_val", i), resp1_val, vecs[i].e_s1v);
         chk($sformatf("vec%0d_mem_resp_rdy", i), mem_resp_rdy, vecs[i].e_mrr);
         chk($sformatf("vec%0d_resp0_opaq", i), resp0_opaq, vecs[i].ro[7:0]);
         chk($sformatf("vec%0d_resp1_opaq", i), resp1_opaq, vecs[i].ro[7:0]);
         chk($sformatf("vec%0d_resp1_msg", i), resp1_msg, 35'h5_1234_5678);
         if (vecs[i].e_mv) begin
            chk($sformatf("vec%0d_mem_req_opaq", i), mem_req_opaq, vecs[i].e_mo);
            chk($sformatf("vec%0d_mem_req_msg", i), mem_req_msg, vecs[i].e_mo[8] ? MSG1 : MSG0);
         end
         rst = 1;
         clear_inputs();
         tick();
         tick();
      end

      // single fetch request and its response
      do_reset();
      req0_val = 1; req0_msg = MSG0; req0_opaq = 8'h05; mem_req_rdy = 1;
      settle();
      chk("t1_mem_req_opaq", mem_req_opaq, 9'h005);
      chk("t1_req0_rdy", req0_rdy, 1'b1);
      chk("t1_mem_req_msg", mem_req_msg, MSG0);
      tick();
      req0_val = 0; mem_req_rdy = 0;
      mem_resp_val = 1; mem_resp_opaq = 9'h005; mem_resp_msg = 35'h0_0000_ABCD; resp0_rdy = 1;
      settle();
      chk("t1_resp0_val", resp0_val, 1'b1);
      chk("t1_resp0_opaq", resp0_opaq, 8'h05);
      chk("t1_resp1_val", resp1_val, 1'b0);
      chk("t1_resp0_msg", resp0_msg, 35'h0_0000_ABCD);
      tick();
      mem_resp_val = 0;

      // alternating grants under continuous contention; responses keep counts low
      do_reset();
      req0_val = 1; req1_val = 1; req0_opaq = 8'h10; req1_opaq = 8'h20;
      req0_msg = MSG0; req1_msg = MSG1; mem_req_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            mem_resp_val = 1;
            mem_resp_opaq = {(((i - 1) % 2) == 1), 8'h00};
         end
         settle();
         chk($sformatf("t2_req0_rdy_c%0d", i), req0_rdy, (i % 2) == 0);
         chk($sformatf("t2_req1_rdy_c%0d", i), req1_rdy, (i % 2) == 1);
         chk($sformatf("t2_grant_id_c%0d", i), mem_req_opaq[8], (i % 2) == 1);
         tick();
      end
`ifdef MEM_REQ_ARBITER_PERF_EN
      chk("t2_perf_grant0", perf_grant0, 32'd4);
      chk("t2_perf_grant1", perf_grant1, 32'd4);
      chk("t2_perf_conflict", perf_conflict, 32'd8);
`endif
      clear_inputs();

      // stall on port 0 with both valid, then hand over to port 1
      do_reset();
      req0_val = 1; req1_val = 1; req0_opaq = 8'h31; req1_opaq = 8'h32;
      req0_msg = MSG0; req1_msg = MSG1; mem_req_rdy = 0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk($sformatf("t3_mem_req_val_c%0d", c), mem_req_val, 1'b1);
         chk($sformatf("t3_req0_rdy_c%0d", c), req0_rdy, 1'b0);
         chk($sformatf("t3_opaq_c%0d", c), mem_req_opaq, 9'h031);
         chk($sformatf("t3_msg_c%0d", c), mem_req_msg, MSG0);
         tick();
      end
      mem_req_rdy = 1;
      settle();
      chk("t3_fire_req0_rdy", req0_rdy, 1'b1);
      chk("t3_fire_opaq", mem_req_opaq, 9'h031);
      tick();
      req0_val = 0;
      settle();
      chk("t3_next_req1_rdy", req1_rdy, 1'b1);
      chk("t3_next_opaq", mem_req_opaq, 9'h132);
      tick();
      clear_inputs();

      // stalled grant on port 1 must not move when port 0 (higher prio) arrives
      do_reset();
      req1_val = 1; req1_opaq = 8'h41; req1_msg = MSG1; req0_opaq = 8'h40; req0_msg = MSG0;
      mem_req_rdy = 0;
      settle();
      chk("t3b_first_opaq", mem_req_opaq, 9'h141);
      tick();
      req0_val = 1;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk($sformatf("t3b_held_opaq_c%0d", c), mem_req_opaq, 9'h141);
         chk($sformatf("t3b_held_msg_c%0d", c), mem_req_msg, MSG1);
         tick();
      end
      mem_req_rdy = 1;
      settle();
      chk("t3b_fire_req1_rdy", req1_rdy, 1'b1);
      chk("t3b_fire_req0_rdy", req0_rdy, 1'b0);
      tick();
      req1_val = 0;
      settle();
      chk("t3b_then_req0_rdy", req0_rdy, 1'b1);
      tick();
      clear_inputs();

      // in-flight cap on port 0
      do_reset();
      req0_val = 1; mem_req_rdy = 1; req1_opaq = 8'h77;
      for (int k = 0; k < MAXF; k++) begin
         req0_opaq = 8'(k);
         settle();
         chk($sformatf("t4_fill_req0_rdy_%0d", k), req0_rdy, 1'b1);
         tick();
      end
      req1_val = 1;
      settle();
      chk("t4_cap_req0_rdy", req0_rdy, 1'b0);
      chk("t4_cap_req1_rdy", req1_rdy, 1'b1);
      chk("t4_cap_opaq", mem_req_opaq, 9'h177);
      tick();
      req1_val = 0;
      mem_resp_val = 1; mem_resp_opaq = 9'h000; resp0_rdy = 1;
      settle();
      chk("t4_resp_mem_resp_rdy", mem_resp_rdy, 1'b1);
      chk("t4_resp_cycle_req0_rdy", req0_rdy, 1'b0);
      chk("t4_resp_cycle_mem_req_val", mem_req_val, 1'b0);
      tick();
      mem_resp_val = 0;
      settle();
      chk("t4_after_resp_req0_rdy", req0_rdy, 1'b1);
      tick();
      clear_inputs();

      // simultaneous request and response fire on port 0 leave the count alone
      do_reset();
      req0_val = 1; mem_req_rdy = 1;
      settle();
      chk("t5_first_req0_rdy", req0_rdy, 1'b1);
      tick();
      mem_resp_val = 1; mem_resp_opaq = 9'h000; resp0_rdy = 1;
      settle();
      chk("t5_both_req0_rdy", req0_rdy, 1'b1);
      chk("t5_both_mem_resp_rdy", mem_resp_rdy, 1'b1);
      tick();
      mem_resp_val = 0;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk($sformatf("t5_refill_req0_rdy_%0d", k), req0_rdy, 1'b1);
         tick();
      end
      settle();
      chk("t5_full_req0_rdy", req0_rdy, 1'b0);
      req0_val = 0;
      req1_val = 1;
      settle();
      tick();
      req1_val = 0; mem_req_rdy = 0;
      mem_resp_val = 1; mem_resp_opaq = 9'h1AB; resp0_rdy = 1; resp1_rdy = 0;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk($sformatf("t5_bp_mem_resp_rdy_c%0d", c), mem_resp_rdy, 1'b0);
         chk($sformatf("t5_bp_resp1_val_c%0d", c), resp1_val, 1'b1);
         chk($sformatf("t5_bp_resp0_val_c%0d", c), resp0_val, 1'b0);
         tick();
      end
      resp1_rdy = 1;
      settle();
      chk("t5_release_mem_resp_rdy", mem_resp_rdy, 1'b1);
      tick();
      clear_inputs();

      // reset while locked with port 1 at its cap
      do_reset();
      req1_val = 1; mem_req_rdy = 1;
      for (int k = 0; k < MAXF; k++) begin
         settle();
         chk($sformatf("t6_fill_req1_rdy_%0d", k), req1_rdy, 1'b1);
         tick();
      end
      settle();
      chk("t6_full_req1_rdy", req1_rdy, 1'b0);
      req0_val = 1; mem_req_rdy = 0;
      settle();
      tick();
      rst = 1; mem_req_rdy = 1; mem_resp_val = 1; mem_resp_opaq = 9'h100;
      resp0_rdy = 1; resp1_rdy = 1;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk($sformatf("t6_rst_outputs_c%0d", c),
             {mem_req_val, req0_rdy, req1_rdy, resp0_val, resp1_val, mem_resp_rdy}, 6'b0);
         tick();
      end
      rst = 0;
      clear_inputs();
      req1_val = 1; mem_req_rdy = 1;
      settle();
      chk("t6_post_req1_rdy", req1_rdy, 1'b1);
      chk("t6_post_grant_id", mem_req_opaq[8], 1'b1);
      req0_val = 1;
      settle();
      chk("t6_post_prio_req0_rdy", req0_rdy, 1'b1);
      chk("t6_post_prio_req1_rdy", req1_rdy, 1'b0);
      tick();
      clear_inputs();

      // randomized traffic against the transaction-level model
      do_reset();
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_last = 1;      // reset priority 0 means port 0 wins the first tie
      m_stall = -1;
      memq.delete();
      rv[0] = 0; rv[1] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (!rv[n]) begin
               rv[n] = ($urandom_range(0, 2) != 0);
               ro[n] = 8'($urandom);
               r96 = {$urandom, $urandom, $urandom};
               rm[n] = r96[66:0];
            end
         end
         req0_val = rv[0]; req0_opaq = ro[0]; req0_msg = rm[0];
         req1_val = rv[1]; req1_opaq = ro[1]; req1_msg = rm[1];
         mem_req_rdy = ($urandom_range(0, 9) < 7);
         resp0_rdy = ($urandom_range(0, 9) < 7);
         resp1_rdy = ($urandom_range(0, 9) < 7);
         r64 = {$urandom, $urandom};
         mem_resp_msg = r64[34:0];
         if (memq.size() > 0 && $urandom_range(0, 9) < 6) begin
            mem_resp_val = 1;
            mem_resp_opaq = memq[0];
         end else begin
            mem_resp_val = 0;
            mem_resp_opaq = 9'($urandom);
         end
         settle();

         e0 = rv[0] && (m_cnt[0] < MAXF);
         e1 = rv[1] && (m_cnt[1] < MAXF);
         ev = 1; eg = 0;
         if (m_stall >= 0) eg = (m_stall == 1);
         else if (e0 && e1) eg = (m_last == 0);
         else if (e1) eg = 1;
         else if (e0) eg = 0;
         else ev = 0;
         rid = mem_resp_opaq[8];
         rrdy = rid ? resp1_rdy : resp0_rdy;

         chk("rnd_mem_req_val", mem_req_val, ev);
         chk("rnd_req0_rdy", req0_rdy, ev && mem_req_rdy && !eg);
         chk("rnd_req1_rdy", req1_rdy, ev && mem_req_rdy && eg);
         if (ev) begin
            chk("rnd_mem_req_opaq", mem_req_opaq, {eg, ro[eg]});
            chk("rnd_mem_req_msg", mem_req_msg, rm[eg]);
         end
         chk("rnd_resp0_val", resp0_val, mem_resp_val && !rid);
         chk("rnd_resp1_val", resp1_val, mem_resp_val && rid);
         chk("rnd_mem_resp_rdy", mem_resp_rdy, rrdy);
         chk("rnd_resp0_opaq", resp0_opaq, mem_resp_opaq[7:0]);
         chk("rnd_resp1_opaq", resp1_opaq, mem_resp_opaq[7:0]);

         if (mem_resp_val && rrdy) begin
            m_cnt[rid] = m_cnt[rid] - 1;
            void'(memq.pop_front());
         end
         if (ev && mem_req_rdy) begin
            m_cnt[eg] = m_cnt[eg] + 1;
            m_last = eg ? 1 : 0;
            m_stall = -1;
            memq.push_back({eg, ro[eg]});
            rv[eg] = 0;
         end else if (ev) begin
            m_stall = eg ? 1 : 0;
         end
         tick();
      end
      clear_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
